// File: rtl/gemm_result_drain.sv
// Purpose : captures a full DIM x DIM GEMM result and drains it one row per beat.
// Latency : mat_valid at edge N gives row 0 on row_data/row_valid in the cycle after edge N.
// Backpr. : valid/ready per row; outputs hold while row_ready=0; mat_valid in mid-stream is dropped (overrun).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   mat_in, mat_valid       packed [row][col][bit] result matrix and its one-cycle strobe
//   row_data, row_idx       current row [col][bit] and its index
//   row_valid, row_ready    row handshake; row_last marks row DIM-1
//   busy                    a captured matrix is still being drained
//   overrun                 one-cycle pulse when a mat_valid is dropped
// Build option: define GEMM_DRAIN_REQUANT_EN to requantize (round, shift by SHIFT,
// saturate to WIDTH bits) every element as it is captured.
module gemm_result_drain #(
  parameter int DIM      = 16,
  parameter int OUT_BITS = 16,
  parameter int WIDTH    = 8,
  parameter int SHIFT    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DIM*DIM*OUT_BITS-1:0]  mat_in,
  input  logic                         mat_valid,
  output logic                         busy,
  output logic [DIM*OUT_BITS-1:0]      row_data,
  output logic [$clog2(DIM)-1:0]       row_idx,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic                         row_last,
  output logic                         overrun
);

  localparam int                IDX_W    = $clog2(DIM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIM - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_row_idx;
  logic                            r_row_valid;
  logic [DIM-1:0][DIM*OUT_BITS-1:0] r_buf;

  logic [DIM-1:0][DIM*OUT_BITS-1:0] w_cap;
  logic                            w_last_beat;
  logic                            w_capture;

  // Illegal configurations leave this marker block in the elaborated hierarchy.
  if (SHIFT < 0 || SHIFT >= OUT_BITS || WIDTH < 1) begin : g_illegal_cfg
  end

  // The final row leaving this cycle frees the buffer for a new matrix.
  assign w_last_beat = r_row_valid & row_ready & (r_row_idx == LAST_IDX);
  assign w_capture   = mat_valid & ((r_state == S_IDLE) | w_last_beat);

`ifdef GEMM_DRAIN_REQUANT_EN
  localparam int              RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [OUT_BITS:0] RND_V = (SHIFT > 0) ? (OUT_BITS+1)'(1) << RND_SH : '0;
  // Shifting past the vector width yields 0, so 0-1 gives all ones: no clamp when WIDTH > OUT_BITS.
  localparam logic [OUT_BITS:0] SAT_MAX = ((OUT_BITS+1)'(1) << WIDTH) - (OUT_BITS+1)'(1);

  logic [OUT_BITS:0] w_sum;
  logic [OUT_BITS:0] w_shf;

  always_comb begin
    w_cap = '0;
    w_sum = '0;
    w_shf = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        w_sum = {1'b0, mat_in[(r*DIM+c)*OUT_BITS +: OUT_BITS]} + RND_V;
        w_shf = w_sum >> SHIFT;
        w_cap[r][c*OUT_BITS +: OUT_BITS] = (w_shf > SAT_MAX) ? SAT_MAX[OUT_BITS-1:0]
                                                              : w_shf[OUT_BITS-1:0];
      end
    end
  end
`else
  always_comb begin
    w_cap = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        w_cap[r][c*OUT_BITS +: OUT_BITS] = mat_in[(r*DIM+c)*OUT_BITS +: OUT_BITS];
      end
    end
  end
`endif

  // Buffer is pure datapath; stale contents after reset are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf <= w_cap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_row_idx   <= '0;
      r_row_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mat_valid) begin
            r_state     <= S_STREAM;
            r_row_idx   <= '0;
            r_row_valid <= 1'b1;
          end
        end
        S_STREAM: begin
          if (row_ready) begin
            if (r_row_idx == LAST_IDX) begin
              r_row_idx <= '0;
              // A coincident mat_valid keeps streaming with no bubble.
              if (!mat_valid) begin
                r_state     <= S_IDLE;
                r_row_valid <= 1'b0;
              end
            end else begin
              r_row_idx <= r_row_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_row_idx   <= '0;
          r_row_valid <= 1'b0;
        end
      endcase
    end
  end

  assign row_idx   = r_row_idx;
  assign row_valid = r_row_valid;
  assign busy      = r_row_valid;
  assign row_last  = r_row_valid & (r_row_idx == LAST_IDX);
  assign row_data  = r_buf[r_row_idx];
  assign overrun   = mat_valid & (r_state == S_STREAM) & ~w_last_beat;

endmodule

// File: tb/tb_gemm_result_drain.sv
module tb_gemm_result_drain;
  localparam int DIM      = 4;
  localparam int OUT_BITS = 16;
  localparam int WIDTH    = 8;
  localparam int SHIFT    = 8;
  localparam int RW       = DIM*OUT_BITS;
  localparam int MW       = DIM*DIM*OUT_BITS;
  localparam int IW       = $clog2(DIM);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [MW-1:0] mat_in = '0;
  logic          mat_valid = 1'b0;
  logic          busy;
  logic [RW-1:0] row_data;
  logic [IW-1:0] row_idx;
  logic          row_valid;
  logic          row_ready = 1'b0;
  logic          row_last;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int n_beats = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic [RW-1:0] dat;
  } beat_t;
  beat_t q[$];

  gemm_result_drain #(.DIM(DIM), .OUT_BITS(OUT_BITS), .WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset_n(reset_n), .mat_in(mat_in), .mat_valid(mat_valid), .busy(busy),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .row_last(row_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Element value as the downstream should see it, from plain integer arithmetic.
  function automatic logic [OUT_BITS-1:0] model_elem(input logic [OUT_BITS-1:0] v);
    longint rq;
    rq = (longint'(v) + ((SHIFT > 0) ? (longint'(1) << (SHIFT-1)) : 0)) / (longint'(1) << SHIFT);
    if (rq > (longint'(1) << WIDTH) - 1) rq = (longint'(1) << WIDTH) - 1;
`ifdef GEMM_DRAIN_REQUANT_EN
    return OUT_BITS'(rq);
`else
    if (rq < 0) return '0;
    return v;
`endif
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int w = 0; w < MW/32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle against the row queue, advance model.
  task automatic cycle(input logic mv, input logic [MW-1:0] m, input logic rdy);
    bit    have, beat, acc;
    beat_t b;
    mat_valid = mv;
    mat_in    = m;
    row_ready = rdy;
    @(negedge clk);
    have = (q.size() != 0);
    check("row_valid", RW'(row_valid), RW'(have));
    check("busy", RW'(busy), RW'(have));
    if (have) begin
      check("row_idx", RW'(row_idx), RW'(q[0].idx));
      check("row_data", row_data, q[0].dat);
      check("row_last", RW'(row_last), RW'(q[0].idx == IW'(DIM-1)));
    end else begin
      check("row_last_idle", RW'(row_last), '0);
    end
    beat = have && rdy;
    acc  = mv && (!have || (q.size() == 1 && beat));
    check("overrun", RW'(overrun), RW'(mv && !acc));
    if (beat) begin
      void'(q.pop_front());
      n_beats++;
    end
    if (acc) begin
      for (int r = 0; r < DIM; r++) begin
        b.idx = IW'(r);
        for (int c = 0; c < DIM; c++)
          b.dat[c*OUT_BITS +: OUT_BITS] = model_elem(m[(r*DIM+c)*OUT_BITS +: OUT_BITS]);
        q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [MW-1:0] m1, m2;
    logic [RW-1:0] rd;
    int            b0;

    // Reset state, asserted before any clock edge.
    #2;
    check("rst_row_valid", RW'(row_valid), '0);
    check("rst_busy", RW'(busy), '0);
    check("rst_row_last", RW'(row_last), '0);
    check("rst_overrun", RW'(overrun), '0);
    check("rst_row_idx", RW'(row_idx), '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(1'b0, '0, 1'b1);

    // Basic drain: element[r][c] = 16r+c, ready always high.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m1[(r*DIM+c)*OUT_BITS +: OUT_BITS] = OUT_BITS'(16*r + c);
    b0 = n_beats;
    cycle(1'b1, m1, 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("basic_beats", RW'(n_beats - b0), RW'(DIM));

    // Backpressure: ready 1,0,0 repeating.
    b0 = n_beats;
    cycle(1'b1, rand_mat(), 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, (i % 3) == 0);
    check("bp_beats", RW'(n_beats - b0), RW'(DIM));
    check("bp_drained", RW'(busy), '0);

    // Back-to-back: second matrix on the row-3 beat.
    m1 = rand_mat();
    m2 = rand_mat();
    cycle(1'b1, m1, 1'b1);
    for (int i = 0; i < DIM-1; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, m2, 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Overrun: mat_valid while row 1 is presented.
    cycle(1'b1, m1, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, m2, 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b0, '0, 1'b1);

    // Reset mid-stream at row 2, then a fresh stream from row 0.
    cycle(1'b1, rand_mat(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("pre_rst_idx", RW'(row_idx), RW'(2));
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", RW'(row_valid), '0);
    check("async_rst_busy", RW'(busy), '0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(1'b1, rand_mat(), 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b0, '0, 1'b1);

    // Requantization corner values in row 0.
    m1 = rand_mat();
    m1[0*OUT_BITS +: OUT_BITS] = 16'h0080;
    m1[1*OUT_BITS +: OUT_BITS] = 16'h017F;
    m1[2*OUT_BITS +: OUT_BITS] = 16'hFFFF;
    cycle(1'b1, m1, 1'b0);
    #3;
    rd = row_data;
`ifdef GEMM_DRAIN_REQUANT_EN
    check("rq_0080", RW'(rd[0 +: OUT_BITS]), RW'(1));
    check("rq_017F", RW'(rd[OUT_BITS +: OUT_BITS]), RW'(1));
    check("rq_FFFF", RW'(rd[2*OUT_BITS +: OUT_BITS]), RW'(255));
`else
    check("raw_0080", RW'(rd[0 +: OUT_BITS]), RW'(16'h0080));
    check("raw_017F", RW'(rd[OUT_BITS +: OUT_BITS]), RW'(16'h017F));
    check("raw_FFFF", RW'(rd[2*OUT_BITS +: OUT_BITS]), RW'(16'hFFFF));
`endif
    for (int i = 0; i < DIM; i++) cycle(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 4) == 0, rand_mat(), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3*DIM; i++) cycle(1'b0, '0, 1'b1);
    check("final_idle", RW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gemm_result_drain.md
GEMM_RESULT_DRAIN -- requirements
Module: gemm_result_drain

Interface
REQ-001 SHALL have parameter DIM, default 16, meaning the matrix dimension (rows = columns).
REQ-002 SHALL have parameter OUT_BITS, default 16, meaning the width of each result element.
REQ-003 SHALL have parameter WIDTH, default 8, meaning the saturation width used when requantization is compiled in.
REQ-004 SHALL have parameter SHIFT, default 8, range 0..OUT_BITS-1, meaning the requantization right-shift amount.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port mat_in, input, DIM*DIM*OUT_BITS bits: packed result matrix [row][col][bit] from the GEMM array.
REQ-008 SHALL have port mat_valid, input, 1 bit: single-cycle pulse meaning mat_in holds a complete result.
REQ-009 SHALL have port busy, output, 1 bit: a captured matrix is not yet fully drained.
REQ-010 SHALL have port row_data, output, DIM*OUT_BITS bits: the current row [col][bit].
REQ-011 SHALL have port row_idx, output, $clog2(DIM) bits: the index of the current row.
REQ-012 SHALL have port row_valid, output, 1 bit: row_data and row_idx are valid.
REQ-013 SHALL have port row_ready, input, 1 bit: downstream accepts the row.
REQ-014 SHALL have port row_last, output, 1 bit: the current row is row DIM-1.
REQ-015 SHALL have port overrun, output, 1 bit: one-cycle pulse when a mat_valid is dropped.

Function
REQ-016 SHALL implement two states: IDLE and STREAM.
REQ-017 In IDLE, mat_valid=1 SHALL capture mat_in into an internal DIM x DIM buffer, clear the row counter and move to STREAM.
REQ-018 Latency SHALL be: mat_valid at edge N gives row_valid=1 with row_idx=0 in the cycle after edge N.
REQ-019 In STREAM, row_valid SHALL be 1, row_data SHALL equal buffer[row_idx], and busy SHALL be 1.
REQ-020 A beat SHALL transfer only when row_valid and row_ready are both 1; the row counter SHALL increment by 1 per beat.
REQ-021 While row_ready=0, row_data, row_idx and row_valid SHALL hold stable.
REQ-022 row_last SHALL equal row_valid AND (row_idx==DIM-1).
REQ-023 On a beat with row_last=1 and mat_valid=0, the block SHALL return to IDLE.
REQ-024 A beat with row_last=1 in the same cycle as mat_valid=1 SHALL capture the new matrix, reset row_idx to 0 and remain in STREAM, so back-to-back matrices stream with no bubble.
REQ-025 mat_valid in STREAM without a last beat SHALL be ignored, with the buffer left unmodified, and overrun SHALL pulse high for exactly that cycle.
REQ-026 In IDLE, row_valid, row_last, busy and overrun SHALL be 0; row_data is don't-care, driven from the buffer.
REQ-027 The row counter SHALL wrap from DIM-1 to 0 only via REQ-023/REQ-024 and SHALL never exceed DIM-1.

Reset
REQ-028 Asserting reset_n=0 SHALL force IDLE, row counter 0, row_valid=0, row_last=0, busy=0, overrun=0, regardless of clk.
REQ-029 Reset mid-STREAM SHALL discard the remaining rows; the buffer contents need not be cleared.
REQ-030 After deassertion, the first mat_valid SHALL be treated per REQ-017.

Configuration
REQ-031 Macro GEMM_DRAIN_REQUANT_EN SHALL select whether requantization is compiled in.
REQ-032 Without GEMM_DRAIN_REQUANT_EN, each row_data element SHALL be the raw captured OUT_BITS value.
REQ-033 With GEMM_DRAIN_REQUANT_EN, each element SHALL be (value + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed unsigned in OUT_BITS+1 bits.
REQ-034 With GEMM_DRAIN_REQUANT_EN, the result SHALL saturate to 2^WIDTH-1 and be zero-extended to OUT_BITS.
REQ-035 With GEMM_DRAIN_REQUANT_EN, requantization SHALL be applied at capture time so that REQ-018 latency is unchanged.

Verification (DIM=4, OUT_BITS=16, WIDTH=8, SHIFT=8)
REQ-036 SHALL cover basic drain: element[r][c]=16*r+c, row_ready=1 -> rows 0..3 on 4 consecutive cycles starting 1 cycle after mat_valid; row_last on row 3; busy falls after row 3.
REQ-037 SHALL cover backpressure: row_ready toggling 1,0,0,1,... -> each row held stable while stalled; exactly 4 beats; no row repeated or skipped.
REQ-038 SHALL cover back-to-back: second mat_valid coincident with the row-3 beat -> next cycle row_idx=0 with new data, row_valid never dropping, overrun=0.
REQ-039 SHALL cover overrun: mat_valid while row_idx=1 -> overrun=1 for one cycle; rows 2..3 still carry the first matrix's data.
REQ-040 SHALL cover reset mid-stream: reset_n=0 at row_idx=2 -> row_valid=0 and busy=0 immediately (asynchronous); next mat_valid streams from row 0.
REQ-041 SHALL cover requantization with GEMM_DRAIN_REQUANT_EN: inputs 0x0080, 0x017F, 0xFFFF -> outputs 1, 1, 255 (saturated); without the macro -> 0x0080, 0x017F, 0xFFFF.
